// File: rtl/lcd_capture_if.sv
// Parallel RGB LCD bus as seen by the capture block, plus the qualified pixel
// stream, measurements, status and debug taps that the capture block returns.
//
// Handshake: there is no back-pressure anywhere. The bus side is qualified by
// tick (a sample is taken only on clock edges where tick=1); the pixel side is
// a one-clock pixel_valid strobe and the consumer must accept it on that clock.
interface lcd_capture_if #(
  parameter int X_BITS   = 10,
  parameter int Y_BITS   = 10,
  parameter int ERR_BITS = 16
);
  // LCD bus (driven by the display pipeline)
  logic                tick;
  logic                hs_n;
  logic                vs_n;
  logic                data_enable;
  logic [7:0]          red;
  logic [7:0]          green;
  logic [7:0]          blue;
  // Captured pixel stream
  logic                pixel_valid;
  logic [X_BITS-1:0]   pixel_x;
  logic [Y_BITS-1:0]   pixel_y;
  logic [7:0]          pixel_red;
  logic [7:0]          pixel_green;
  logic [7:0]          pixel_blue;
  // Frame timing measurement and status
  logic                frame_start;
  logic [X_BITS-1:0]   width;
  logic [Y_BITS-1:0]   height;
  logic                locked;
  logic                line_error;
  logic                frame_error;
  logic [ERR_BITS-1:0] error_count;
  // Debug taps: FSM state and last sampled hs_n level
  logic [1:0]          state_dbg;
  logic                hs_n_dbg;

  modport master (
    output tick, hs_n, vs_n, data_enable, red, green, blue,
    input  pixel_valid, pixel_x, pixel_y, pixel_red, pixel_green, pixel_blue,
    input  frame_start, width, height, locked, line_error, frame_error,
    input  error_count, state_dbg, hs_n_dbg
  );

  modport slave (
    input  tick, hs_n, vs_n, data_enable, red, green, blue,
    output pixel_valid, pixel_x, pixel_y, pixel_red, pixel_green, pixel_blue,
    output frame_start, width, height, locked, line_error, frame_error,
    output error_count, state_dbg, hs_n_dbg
  );
endinterface

// File: rtl/lcd_capture.sv
// Receiving end of the parallel RGB LCD bus. Regenerates pixel coordinates
// from DE/VS, emits a qualified pixel stream, measures active width/height and
// tracks lock with line/frame error reporting. hs_n does not take part in
// counting; DE alone delimits lines.
module lcd_capture #(
  parameter int X_BITS   = 10,
  parameter int Y_BITS   = 10,
  parameter int ERR_BITS = 16
) (
  input logic         clock,
  input logic         reset,
  lcd_capture_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state_q;
  logic                prev_vs_n_q;
  logic                prev_de_q;
  logic                hs_n_q;
  logic [X_BITS-1:0]   x_count_q;
  logic [Y_BITS-1:0]   y_count_q;
  logic                ovf_q;        // current line saw a pixel with x saturated
  logic                first_line_q; // next closed line is the first of the frame
  logic                skip_line_q;  // line was already open at vs_fall: discard it
  logic                meas_bad_q;
  logic                pixel_valid_q;
  logic [X_BITS-1:0]   pixel_x_q;
  logic [Y_BITS-1:0]   pixel_y_q;
  logic [7:0]          pixel_red_q;
  logic [7:0]          pixel_green_q;
  logic [7:0]          pixel_blue_q;
  logic                frame_start_q;
  logic [X_BITS-1:0]   width_q;
  logic [Y_BITS-1:0]   height_q;
  logic                line_error_q;
  logic                frame_error_q;
  logic [ERR_BITS-1:0] error_count_q;

  // Per-tick decode; only consumed on clocks where tick=1.
  logic                vs_fall;
  logic                de_fall;
  logic                line_close;
  logic                px_take;
  logic                x_at_max;
  logic                line_bad;
  logic [Y_BITS-1:0]   y_line_d;
  logic                line_err_d;
  logic                frame_err_d;
  logic                meas_bad_line;
  logic [ERR_BITS:0]   err_sum;
  logic [ERR_BITS-1:0] err_count_d;

  assign vs_fall    = prev_vs_n_q & ~bus.vs_n;
  assign de_fall    = prev_de_q & ~bus.data_enable;
  assign line_close = de_fall & ~skip_line_q;
  assign px_take    = bus.data_enable & (state_q != HUNT);
  assign x_at_max   = &x_count_q;
  assign line_bad   = (x_count_q != width_q) | ovf_q;
  // y after the line close: the frame close on the same tick sees this value
  assign y_line_d   = (line_close && !(&y_count_q)) ? y_count_q + 1'b1 : y_count_q;
  assign line_err_d = line_close & (state_q == LOCKED) & line_bad;
  // In MEASURE the first line defines width, so only its overflow is bad
  assign meas_bad_line = line_close & (state_q == MEASURE) &
                         (first_line_q ? ovf_q : line_bad);
  // Frame check uses the state at the start of the tick, so a line error and a
  // frame error can both be reported on one tick
  assign frame_err_d = vs_fall & (state_q == LOCKED) & (y_line_d != height_q);

  // Saturating add of up to two error events
  always_comb begin
    err_sum     = {1'b0, error_count_q}
                + {{ERR_BITS{1'b0}}, line_err_d}
                + {{ERR_BITS{1'b0}}, frame_err_d};
    err_count_d = err_sum[ERR_BITS] ? {ERR_BITS{1'b1}} : err_sum[ERR_BITS-1:0];
  end

  // Sampling, counters, pixel path and lock FSM, advanced only on ticks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      prev_vs_n_q   <= 1'b1;
      prev_de_q     <= 1'b0;
      hs_n_q        <= 1'b0;
      x_count_q     <= '0;
      y_count_q     <= '0;
      ovf_q         <= 1'b0;
      first_line_q  <= 1'b0;
      skip_line_q   <= 1'b0;
      meas_bad_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_red_q   <= '0;
      pixel_green_q <= '0;
      pixel_blue_q  <= '0;
      frame_start_q <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      line_error_q  <= 1'b0;
      frame_error_q <= 1'b0;
      error_count_q <= '0;
    end else if (bus.tick) begin
      prev_vs_n_q   <= bus.vs_n;
      prev_de_q     <= bus.data_enable;
      hs_n_q        <= bus.hs_n;
      pixel_valid_q <= px_take;
      frame_start_q <= vs_fall;
      line_error_q  <= line_err_d;
      frame_error_q <= frame_err_d;
      error_count_q <= err_count_d;

      if (px_take) begin
        pixel_x_q     <= x_count_q;
        pixel_y_q     <= y_count_q;
        pixel_red_q   <= bus.red;
        pixel_green_q <= bus.green;
        pixel_blue_q  <= bus.blue;
      end

      if (vs_fall || de_fall) begin
        x_count_q <= '0;
        ovf_q     <= 1'b0;
      end else if (bus.data_enable) begin
        if (x_at_max) ovf_q <= 1'b1;
        else          x_count_q <= x_count_q + 1'b1;
      end

      y_count_q <= vs_fall ? '0 : y_line_d;

      if (vs_fall) begin
        first_line_q <= 1'b1;
        skip_line_q  <= bus.data_enable;
      end else if (de_fall) begin
        first_line_q <= skip_line_q ? first_line_q : 1'b0;
        skip_line_q  <= 1'b0;
      end

      case (state_q)
        HUNT: begin
          if (vs_fall) begin
            state_q    <= MEASURE;
            meas_bad_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (line_close && first_line_q) width_q <= x_count_q;
          if (vs_fall) begin
            if (!(meas_bad_q || meas_bad_line) && (y_line_d != '0)) begin
              height_q <= y_line_d;
              state_q  <= LOCKED;
            end
            meas_bad_q <= 1'b0;
          end else if (meas_bad_line) begin
            meas_bad_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (vs_fall) begin
            if (frame_err_d || line_err_d) state_q <= MEASURE;
            meas_bad_q <= 1'b0;
          end else if (line_err_d) begin
            state_q    <= MEASURE;
            meas_bad_q <= 1'b1;
          end
        end
        default: state_q <= HUNT;
      endcase
    end else begin
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      line_error_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end
  end

  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.pixel_red   = pixel_red_q;
  assign bus.pixel_green = pixel_green_q;
  assign bus.pixel_blue  = pixel_blue_q;
  assign bus.frame_start = frame_start_q;
  assign bus.width       = width_q;
  assign bus.height      = height_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.line_error  = line_error_q;
  assign bus.frame_error = frame_error_q;
  assign bus.error_count = error_count_q;
  assign bus.state_dbg   = state_q;
  assign bus.hs_n_dbg    = hs_n_q;

endmodule

// File: doc/lcd_capture.md
Name: lcd_capture

Overview:
- Receiving end of the parallel RGB LCD bus that the display pipeline drives (pixel tick, hs_n, vs_n, data_enable, 8-bit R/G/B).
- Samples the bus and regenerates pixel coordinates from DE/VS, then emits a qualified pixel stream.
- Measures active width and height and reports lock and timing errors.
- Used as a loopback checker on the GPIO header and as a capture front end for a later frame grabber.

Parameters:
X_BITS, 10, width of x counter and measured width
Y_BITS, 10, width of y counter and measured height
ERR_BITS, 16, width of the saturating error counter

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
tick  in  1  pixel enable; bus is sampled only on clock edges where tick=1
hs_n  in  1  horizontal sync, active low (monitored only)
vs_n  in  1  vertical sync, active low
data_enable  in  1  active-pixel qualifier
red, green, blue  in  8 each  pixel colour
pixel_valid  out  1  one-clock strobe per captured pixel
pixel_x  out  X_BITS  column of the captured pixel
pixel_y  out  Y_BITS  row of the captured pixel
pixel_red, pixel_green, pixel_blue  out  8 each  captured colour
frame_start  out  1  one-clock strobe on each vs_n falling edge
width  out  X_BITS  reference active width (DE-high ticks per line)
height  out  Y_BITS  reference active lines per frame
locked  out  1  high in LOCKED state
line_error  out  1  one-clock strobe on a line-width mismatch or overflow
frame_error  out  1  one-clock strobe on a frame-height mismatch
error_count  out  ERR_BITS  saturating count of line_error plus frame_error events

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state=HUNT.
  - Previous-sample registers: prev_vs_n=1, prev_de=0.
  - x_count=0, y_count=0.
- Sampling:
  - All inputs are synchronous to clock.
  - Nothing changes on clocks with tick=0; all strobes are low on those clocks.
  - On a tick, edges are computed against prev_*, then prev_* is updated.
  - vs_fall = prev_vs_n & ~vs_n; de_fall = prev_de & ~data_enable.
- Pixel path:
  - On a tick with data_enable=1 and state not HUNT, the next clock edge registers pixel_valid=1, pixel_x=x_count, pixel_y=y_count and the colour inputs.
  - Latency is exactly 1 clock. pixel_valid drops on the following clock.
  - x_count increments and saturates at all-ones. A saturated line counts as an overflow.
- Line close (de_fall):
  - line_len=x_count; x_count<=0; y_count increments (saturating).
  - MEASURE: the first line of the frame sets width<=line_len. Any later line with line_len != width, or an overflow, sets meas_bad.
  - LOCKED: line_len != width or overflow -> line_error=1, error_count++, state<=MEASURE, meas_bad<=1.
- Frame close (vs_fall):
  - frame_start=1; y_count<=0; x_count<=0.
  - A DE-high line in progress is discarded without a line check.
  - HUNT -> MEASURE, with meas_bad=0.
  - MEASURE: if meas_bad=0 and y_count>0 -> height<=y_count, state<=LOCKED. Otherwise stay in MEASURE with meas_bad<=0.
  - LOCKED: if y_count != height -> frame_error=1, error_count++, state<=MEASURE.
- Simultaneous de_fall and vs_fall on one tick: the line is closed first (width check and y_count increment), then the frame is closed using the incremented y_count.
- A line_error and a frame_error on the same tick increment error_count by 2, saturating at all-ones.
- error_count clears only on reset. width and height hold their last values through MEASURE.
- hs_n is ignored for counting; DE alone defines lines.

Test Plan:
- Reset mid-line (reset asserted during DE) -> all outputs 0 within the same clock; no pixel_valid until after the next vs_fall.
- Three frames of 8 active pixels x 4 lines, tick every other clock:
  - Frame 1 produces no pixel_valid.
  - Frame 2 produces 32 strobes with x 0..7 and y 0..3, colour echoed 1 clock after its tick.
  - At the 3rd vs_fall: locked=1, width=8, height=4.
- Locked stream, third line only 7 pixels -> line_error strobe at the next clock, error_count=1, locked=0. The next clean frame relocks at the following vs_fall.
- Locked stream, frame of 5 lines of 8 -> frame_error at vs_fall, error_count increments, locked=0.
- The last de_fall and vs_fall on the same tick for a 4-line frame -> counted as 4 lines, no frame_error, lock retained.
- ERR_BITS=2 with 5 induced errors -> error_count saturates at 3; tick held low for 10 clocks -> no output changes.
